// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter
//   Shares one single-port scratchpad RAM between NREQ burst requesters.
//   Requesters are granted round-robin; a granted burst owns the RAM port until
//   its final beat. The block generates sequential addresses and drives the RAM
//   port. It returns read data one cycle after each address, tagged to the
//   requester that owned the burst.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   req_valid  per-requester command valid (held until req_ready)
//   req_ready  one-hot command accept, combinational, IDLE only
//   req_we     per-requester command type (1 = write burst)
//   req_addr   per-requester burst start address (slice i = requester i)
//   req_len    per-requester beats minus one
//   wdata      per-requester write byte
//   wvalid     per-requester write byte valid
//   wready     one-hot, owner of an active write burst
//   rdata      read byte, qualified by rvalid
//   rvalid     one-hot read strobe to the owner of the read burst
//   busy       high while a burst owns the port
//   mem_wen    RAM write enable
//   mem_addr   RAM address
//   mem_din    RAM write data
//   mem_dout   RAM read data, one cycle after mem_addr
module scratchpad_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int LW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*LW-1:0] req_len,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    wvalid,
  output logic [NREQ-1:0]    wready,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic               busy,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_din,
  input  logic [DW-1:0]      mem_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   idx;
  logic            grant_any;
  logic            we_q;
  logic [AW-1:0]   cur_addr_q;
  logic [AW-1:0]   addr_hold_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   beat_q;
  logic            beat_adv;
  logic            last_beat;
  logic [NREQ-1:0] own_oh;
  logic            rd_vld_p1;
  logic [IW-1:0]   rd_own_p1;

  // Round-robin scan starting one past the previous winner.
  always_comb begin
    winner    = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        winner    = idx;
      end
    end
  end

  assign busy      = (state_q == BURST);
  assign own_oh    = NREQ'(1) << owner_q;
  // Reads advance every cycle; writes only when the owner's byte is present.
  assign beat_adv  = busy && (!we_q || wvalid[owner_q]);
  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          // IDLE is also the reset state; gating with rst keeps req_ready low
          // while reset is held.
          req_ready[winner] = rst;
          state_d           = BURST;
        end
      end
      BURST: begin
        if (beat_adv && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port: combinational from state so reset drops mem_wen immediately.
  assign wready   = (busy && we_q) ? own_oh : '0;
  assign mem_wen  = busy && we_q && wvalid[owner_q];
  assign mem_din  = (busy && we_q) ? wdata[int'(owner_q)*DW +: DW] : '0;
  assign mem_addr = busy ? cur_addr_q : addr_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(NREQ - 1);
      owner_q     <= '0;
      we_q        <= 1'b0;
      cur_addr_q  <= '0;
      addr_hold_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rd_vld_p1   <= 1'b0;
      rd_own_p1   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_any) begin
        rr_ptr_q   <= winner;
        owner_q    <= winner;
        we_q       <= req_we[winner];
        cur_addr_q <= req_addr[int'(winner)*AW +: AW];
        len_q      <= req_len[int'(winner)*LW +: LW];
        beat_q     <= '0;
      end else if (beat_adv) begin
        // addr_hold_q keeps the last issued address visible once back in IDLE.
        addr_hold_q <= cur_addr_q;
        cur_addr_q  <= cur_addr_q + AW'(1);
        beat_q      <= beat_q + LW'(1);
      end
      // ---- stage p1: read beat flag, aligned with registered RAM output ----
      // The owner is captured here so a final beat returned during a new grant
      // stays tagged to the old owner.
      rd_vld_p1 <= busy && !we_q;
      rd_own_p1 <= owner_q;
    end
  end

  assign rvalid = rd_vld_p1 ? (NREQ'(1) << rd_own_p1) : '0;
  assign rdata  = rd_vld_p1 ? mem_dout : '0;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Testbench for scratchpad_arbiter: behavioural RAM, reference memory,
// per-requester expectation queues and a negedge monitor.
module tb_scratchpad_arbiter;

  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid, req_ready, req_we, wvalid, wready, rvalid;
  logic [NR*16-1:0] req_addr;
  logic [NR*8-1:0] req_len, wdata;
  logic [7:0]      rdata, mem_din, mem_dout;
  logic            busy, mem_wen;
  logic [15:0]     mem_addr;

  logic        tb_valid [NR];
  logic        tb_we    [NR];
  logic [15:0] tb_addr  [NR];
  logic [7:0]  tb_len   [NR];
  logic [7:0]  tb_wdata [NR];
  logic        tb_wvalid[NR];

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  wbytes  [NR][256];

  logic [7:0]  exp_rd [NR][$];
  logic [23:0] exp_wr [NR][$];
  int          grant_id_log[$];
  int          grant_cyc_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rv_cnt   = 0;
  int wen_cnt  = 0;
  int busy_cnt = 0;
  int model_last = NR - 1;
  bit await_rv [NR];
  int gcyc     [NR];

  scratchpad_arbiter #(.NREQ(NR), .AW(16), .DW(8), .LW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = tb_valid[i];
      req_we[i]            = tb_we[i];
      req_addr[i*16 +: 16] = tb_addr[i];
      req_len[i*8 +: 8]    = tb_len[i];
      wdata[i*8 +: 8]      = tb_wdata[i];
      wvalid[i]            = tb_wvalid[i];
    end
  end

  // Single-port RAM, registered read, read-before-write.
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr];
    if (mem_wen) ram[mem_addr] = mem_din;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: grants against a round-robin model, read data and writes
  // against the per-requester expectation queues.
  always @(negedge clk) begin : mon
    int ew;
    int o;
    logic [23:0] e;
    if (!rst) begin
      model_last = NR - 1;
      for (int i = 0; i < NR; i++) await_rv[i] = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (!busy && req_valid != '0) chk("grant_present", 32'(req_ready != '0), 1);
      if (req_ready != '0) begin
        ew = -1;
        for (int k = 1; k <= NR; k++)
          if (ew < 0 && req_valid[(model_last + k) % NR]) ew = (model_last + k) % NR;
        chk("grant_winner", 32'(req_ready), 32'(1 << ew));
        chk("grant_idle", 32'(busy), 0);
        model_last = ew;
        grant_id_log.push_back(ew);
        grant_cyc_log.push_back(cyc);
        if (!req_we[ew]) begin
          await_rv[ew] = 1'b1;
          gcyc[ew]     = cyc;
        end
      end
      if (rvalid != '0) begin
        rv_cnt++;
        chk("rvalid_onehot", 32'($onehot(rvalid)), 1);
        o = 0;
        for (int i = 0; i < NR; i++) if (rvalid[i]) o = i;
        if (exp_rd[o].size() == 0) chk("rd_unexpected", 32'(rvalid), 0);
        else chk("rdata", 32'(rdata), 32'(exp_rd[o].pop_front()));
        if (await_rv[o]) begin
          chk("rd_latency", 32'(cyc - gcyc[o]), 2);
          await_rv[o] = 1'b0;
        end
      end
      if (mem_wen) begin
        wen_cnt++;
        chk("wready_onehot", 32'($onehot(wready)), 1);
        o = 0;
        for (int i = 0; i < NR; i++) if (wready[i]) o = i;
        if (exp_wr[o].size() == 0) chk("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          e = exp_wr[o].pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[23:8]));
          chk("wr_data", 32'(mem_din), 32'(e[7:0]));
        end
      end
    end
  end

  // Expected responses derived from the reference memory.
  task automatic push_exp(input int i, input bit we, input logic [15:0] a,
                          input logic [7:0] len, input int dbase);
    logic [15:0] ad;
    for (int k = 0; k <= int'(len); k++) begin
      ad = a + 16'(k);
      if (we) begin
        wbytes[i][k] = (dbase >= 0) ? 8'(dbase + k) : 8'($urandom);
        exp_wr[i].push_back({ad, wbytes[i][k]});
        ref_mem[ad] = wbytes[i][k];
      end else begin
        exp_rd[i].push_back(ref_mem[ad]);
      end
    end
  endtask

  task automatic issue(input int i, input bit we, input logic [15:0] a, input logic [7:0] len);
    int n;
    tb_we[i] = we; tb_addr[i] = a; tb_len[i] = len; tb_valid[i] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", 32'(n), 0);
        break;
      end
    end
    @(posedge clk); #1;
    tb_valid[i] = 1'b0;
  endtask

  // stall: 0 none, 1 two idle cycles after the first byte, 2 random
  task automatic feed(input int i, input logic [7:0] len, input int stall);
    int k, n, lowcnt;
    bit go;
    k = 0; n = 0; lowcnt = 0;
    while (k <= int'(len) && n < 5000) begin
      go = 1'b1;
      if (stall == 1 && k == 1 && lowcnt < 2) begin go = 1'b0; lowcnt++; end
      if (stall == 2 && $urandom_range(0, 3) == 0) go = 1'b0;
      tb_wvalid[i] = go;
      tb_wdata[i]  = wbytes[i][k];
      @(negedge clk);
      if (go && wready[i]) k++;
      @(posedge clk); #1;
      n++;
    end
    tb_wvalid[i] = 1'b0;
    if (n >= 5000) chk("feed_timeout", 32'(k), 32'(len) + 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 2000 && (busy || exp_rd[0].size() != 0 || exp_rd[1].size() != 0 ||
                        exp_wr[0].size() != 0 || exp_wr[1].size() != 0)) begin
      @(posedge clk); n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'(n), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input int i, input bit we, input logic [15:0] a,
                         input logic [7:0] len, input int stall, input int dbase);
    push_exp(i, we, a, len, dbase);
    issue(i, we, a, len);
    if (we) feed(i, len, stall);
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'(i ^ (i >> 8) ^ 8'h5A);
      ref_mem[i] = ram[i];
    end
    for (int k = 0; k < 4; k++) begin
      ram[16'h0010 + k]     = 8'(8'h11 * (k + 1));
      ref_mem[16'h0010 + k] = 8'(8'h11 * (k + 1));
    end
    for (int i = 0; i < NR; i++) begin
      tb_valid[i] = 0; tb_we[i] = 0; tb_addr[i] = '0; tb_len[i] = '0;
      tb_wdata[i] = '0; tb_wvalid[i] = 0;
    end

    // Reset values, with a request pending to confirm req_ready stays low.
    tb_valid[0] = 1'b1;
    tb_wvalid[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_wready", 32'(wready), 0);
    tb_valid[0] = 1'b0;
    tb_wvalid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1. Read burst of preloaded bytes.
    b0 = rv_cnt;
    run_cmd(0, 1'b0, 16'h0010, 8'd3, 0, -1);
    chk("t1_rv_count", 32'(rv_cnt - b0), 4);

    // 2. Write with a two-cycle stall, then read back.
    b0 = wen_cnt;
    run_cmd(1, 1'b1, 16'h0100, 8'd2, 1, 8'hA0);
    chk("t2_wen_count", 32'(wen_cnt - b0), 3);
    run_cmd(1, 1'b0, 16'h0100, 8'd2, 0, -1);

    // 3. Round-robin with both requesters continuously valid, len=0.
    grant_id_log.delete();
    grant_cyc_log.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          push_exp(0, 1'b0, 16'h0300 + 16'(k), 8'd0, -1);
          issue(0, 1'b0, 16'h0300 + 16'(k), 8'd0);
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          push_exp(1, 1'b0, 16'h0400 + 16'(k), 8'd0, -1);
          issue(1, 1'b0, 16'h0400 + 16'(k), 8'd0);
        end
      end
    join
    drain();
    chk("t3_grant_count", 32'(grant_id_log.size()), 8);
    if (grant_id_log.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("t3_grant_order", 32'(grant_id_log[k]), 32'(k % 2));
      for (int k = 1; k < 8; k++)
        chk("t3_grant_gap", 32'(grant_cyc_log[k] - grant_cyc_log[k-1]), 2);
    end

    // 4. Address wrap at the top of memory.
    run_cmd(0, 1'b0, 16'hFFFE, 8'd3, 0, -1);
    chk("t4_addr_hold", 32'(mem_addr), 32'h0001);
    chk("t4_idle_wen", 32'(mem_wen), 0);

    // 5. Reset during beat index 3 of an 8-beat write: only beats 0..2 land.
    for (int k = 0; k < 8; k++) wbytes[0][k] = 8'(8'hC0 + k);
    for (int k = 0; k < 3; k++) begin
      exp_wr[0].push_back({16'h0200 + 16'(k), wbytes[0][k]});
      ref_mem[16'h0200 + k] = wbytes[0][k];
    end
    issue(0, 1'b1, 16'h0200, 8'd7);
    for (int k = 0; k < 3; k++) begin
      tb_wvalid[0] = 1'b1; tb_wdata[0] = wbytes[0][k];
      @(posedge clk); #1;
    end
    tb_wvalid[0] = 1'b1; tb_wdata[0] = wbytes[0][3];
    #1;
    chk("t5_pre_rst_wen", 32'(mem_wen), 1);
    rst = 1'b0;
    #1;
    chk("t5_async_wen", 32'(mem_wen), 0);
    chk("t5_async_busy", 32'(busy), 0);
    chk("t5_async_wready", 32'(wready), 0);
    tb_wvalid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("t5_writes_done", 32'(exp_wr[0].size()), 0);
    grant_id_log.delete();
    fork
      run_cmd(1, 1'b0, 16'h0200, 8'd7, 0, -1);
      run_cmd(0, 1'b0, 16'h0200, 8'd7, 0, -1);
    join
    chk("t5_log_size", 32'(grant_id_log.size()), 2);
    if (grant_id_log.size() > 0) chk("t5_first_grant", 32'(grant_id_log[0]), 0);

    // 6. Maximum length read.
    b0 = rv_cnt;
    b1 = busy_cnt;
    run_cmd(1, 1'b0, 16'(($urandom)), 8'd255, 0, -1);
    chk("t6_rv_count", 32'(rv_cnt - b0), 256);
    chk("t6_busy_cycles", 32'(busy_cnt - b1), 256);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      run_cmd($urandom_range(0, NR-1), 1'($urandom_range(0, 1)), 16'($urandom),
              8'($urandom_range(0, 15)), 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
